bg_scaler_renderer: RTL and testbench

BG_SCALER_RENDERER -- requirements
Module: bg_scaler_renderer

---
 rtl/bg_scaler_renderer.sv | 190 +++++++++++++++++++
 tb/tb_bg_scaler_renderer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_scaler_renderer.sv
`default_nettype none
// ============================================================================
// Module      : bg_scaler_renderer
// Description : Scales a palette-indexed background image onto the active
//               display. Texel column/row come from incremental accumulators
//               (no multiply/divide). The ROM address is registered, the ROM
//               answers ROM_LAT cycles later, and the palette colour is
//               registered into red/green/blue. Total latency is ROM_LAT+2.
//               Optional macro BG_SCALER_SCROLL_EN enables a horizontal scroll
//               offset that is latched at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module bg_scaler_renderer #(
    parameter int IMG_W    = 175,
    parameter int IMG_H    = 480,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int IDX_W    = 5,
    parameter int ADDR_W   = 17,
    parameter int ROM_LAT  = 1
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        scroll_x,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
);

    localparam logic [10:0]       C_IMG_W    = 11'(IMG_W);
    localparam logic [10:0]       C_IMG_H    = 11'(IMG_H);
    localparam logic [10:0]       C_SCR_W    = 11'(SCREEN_W);
    localparam logic [10:0]       C_SCR_H    = 11'(SCREEN_H);
    localparam logic [ADDR_W-1:0] C_ROW_STEP = ADDR_W'(IMG_W);

    logic [9:0]        r_prev_x, r_prev_y;
    logic [10:0]       r_hacc, r_vacc;
    logic [9:0]        r_col, r_row;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_rom_address;
    logic [ROM_LAT:0]  r_blank_dly;
    logic              r_synced;
    logic [3:0]        r_red, r_green, r_blue;

    logic              w_active;
    logic              w_frame_start;
    logic              w_blank_in;
    logic [10:0]       w_hacc, w_hacc_sum, w_vacc, w_vacc_sum;
    logic [9:0]        w_col, w_row;
    logic [ADDR_W-1:0] w_row_base;
    logic [9:0]        w_scroll;
    logic [10:0]       w_col_sum, w_col_mod;

    assign w_active      = ({1'b0, DrawX} < C_SCR_W) && ({1'b0, DrawY} < C_SCR_H);
    assign w_frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

`ifdef BG_SCALER_SCROLL_EN
    logic [9:0] r_scroll_off;
    logic       w_scroll_ok;

    // Out-of-range requests are dropped so the previous offset stays in force.
    assign w_scroll_ok = w_frame_start && ({1'b0, scroll_x} < C_IMG_W);
    // The frame-start pixel already uses the newly accepted offset.
    assign w_scroll    = w_scroll_ok ? scroll_x : r_scroll_off;

    // Latch the scroll offset only at frame start.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n)           r_scroll_off <= '0;
        else if (w_scroll_ok) r_scroll_off <= scroll_x;
    end
`else
    logic w_unused_scroll;
    assign w_unused_scroll = ^scroll_x;
    assign w_scroll        = '0;
`endif

    // Horizontal step: restart at x=0, advance one IMG_W/SCREEN_W step per new x.
    always_comb begin
        w_hacc_sum = r_hacc + C_IMG_W;
        w_hacc     = r_hacc;
        w_col      = r_col;
        if (DrawX == 10'd0) begin
            w_hacc = '0;
            w_col  = '0;
        end else if (DrawX != r_prev_x) begin
            if (w_hacc_sum >= C_SCR_W) begin
                w_hacc = w_hacc_sum - C_SCR_W;
                w_col  = r_col + 10'd1;
            end else begin
                w_hacc = w_hacc_sum;
            end
        end
    end

    // Vertical step: same rule per new line; row_base tracks row*IMG_W.
    always_comb begin
        w_vacc_sum = r_vacc + C_IMG_H;
        w_vacc     = r_vacc;
        w_row      = r_row;
        w_row_base = r_row_base;
        if (DrawY == 10'd0) begin
            w_vacc     = '0;
            w_row      = '0;
            w_row_base = '0;
        end else if (DrawY != r_prev_y) begin
            if (w_vacc_sum >= C_SCR_H) begin
                w_vacc     = w_vacc_sum - C_SCR_H;
                w_row      = r_row + 10'd1;
                w_row_base = r_row_base + C_ROW_STEP;
            end else begin
                w_vacc = w_vacc_sum;
            end
        end
    end

    // Both col and scroll are below IMG_W, so one conditional subtract wraps.
    assign w_col_sum = {1'b0, w_col} + {1'b0, w_scroll};
    assign w_col_mod = (w_col_sum >= C_IMG_W) ? (w_col_sum - C_IMG_W) : w_col_sum;

    // Coordinate state and ROM address; everything holds outside the active area.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_x      <= '0;
            r_prev_y      <= '0;
            r_hacc        <= '0;
            r_vacc        <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_row_base    <= '0;
            r_rom_address <= '0;
        end else if (w_active) begin
            r_prev_x      <= DrawX;
            r_prev_y      <= DrawY;
            r_hacc        <= w_hacc;
            r_vacc        <= w_vacc;
            r_col         <= w_col;
            r_row         <= w_row;
            r_row_base    <= w_row_base;
            r_rom_address <= w_row_base + ADDR_W'(w_col_mod);
        end
    end

    // Until the first frame start, video is treated as blanked at the pipe entry.
    assign w_blank_in = blank & (r_synced | w_frame_start);

    // Synced flag and blank delay line matching address + ROM latency.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_synced    <= 1'b0;
            r_blank_dly <= '0;
        end else begin
            if (w_frame_start) r_synced <= 1'b1;
            r_blank_dly <= {r_blank_dly[ROM_LAT-1:0], w_blank_in};
        end
    end

    // Output colour register, black whenever the delayed blank says so.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (r_blank_dly[ROM_LAT]) begin
            r_red   <= pal_red;
            r_green <= pal_green;
            r_blue  <= pal_blue;
        end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end
    end

    assign rom_address = r_rom_address;
    assign pal_index   = rom_q;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_bg_scaler_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bg_scaler_renderer
// Description : Self-checking bench for bg_scaler_renderer with a scoreboard
//               of expected ROM addresses and pixel colours.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bg_scaler_renderer;

    localparam int IMG_W    = 175;
    localparam int IMG_H    = 480;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
`ifdef BG_SCALER_SCROLL_EN
    localparam bit SCROLL_EN = 1'b1;
`else
    localparam bit SCROLL_EN = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [31:0] v;
    } exp_t;

    logic        vga_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [9:0]  DrawX   = '0;
    logic [9:0]  DrawY   = '0;
    logic        blank   = 1'b0;
    logic [9:0]  scroll_x = '0;
    logic [16:0] rom_address;
    logic [4:0]  rom_q = '0;
    logic [4:0]  pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic [3:0]  red, green, blue;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q_addr[$];
    exp_t q_rgb[$];
    exp_t mon_e;
    bit   m_synced = 1'b0;
    int   m_off = 0;
    int   m_addr = 0;

    bg_scaler_renderer dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .scroll_x   (scroll_x),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .pal_index  (pal_index),
        .pal_red    (pal_red),
        .pal_green  (pal_green),
        .pal_blue   (pal_blue),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc <= cyc + 1;

    function automatic logic [4:0] rom_f(input logic [16:0] a);
        return a[4:0] ^ a[9:5] ^ a[14:10];
    endfunction

    function automatic logic [11:0] pal_rgb(input logic [4:0] idx);
        return {idx[3:0], idx[4:1], ~idx[3:0]};
    endfunction

    // Synchronous ROM with one cycle of latency, combinational palette.
    always @(posedge vga_clk) rom_q <= rom_f(rom_address);
    assign pal_red   = pal_index[3:0];
    assign pal_green = pal_index[4:1];
    assign pal_blue  = ~pal_index[3:0];

    // Scoreboard: pop entries as they fall due and compare with DUT outputs.
    always @(negedge vga_clk) begin
        while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
            mon_e = q_addr.pop_front();
            if (mon_e.due == cyc) begin
                n_checks++;
                if (rom_address !== mon_e.v[16:0]) begin
                    n_fail++;
                    $display("FAIL sb_addr cyc=%0d got=%0d exp=%0d", cyc, rom_address, mon_e.v[16:0]);
                end
            end
        end
        while (q_rgb.size() > 0 && q_rgb[0].due <= cyc) begin
            mon_e = q_rgb.pop_front();
            if (mon_e.due == cyc) begin
                n_checks++;
                if ({red, green, blue} !== mon_e.v[11:0]) begin
                    n_fail++;
                    $display("FAIL sb_rgb cyc=%0d got=%h exp=%h", cyc, {red, green, blue}, mon_e.v[11:0]);
                end
            end
        end
    end

    // Drive one pixel at a negedge, record expectations, return at the next negedge.
    task automatic drive(input int x, input int y, input bit b);
        logic [16:0] a;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        if (x == 0 && y == 0) begin
            m_synced = 1'b1;
            if (SCROLL_EN && int'(scroll_x) < IMG_W) m_off = int'(scroll_x);
        end
        if (x < SCREEN_W && y < SCREEN_H)
            m_addr = (y * IMG_H / SCREEN_H) * IMG_W + (((x * IMG_W / SCREEN_W) + m_off) % IMG_W);
        a = 17'(m_addr);
        if (m_synced) q_addr.push_back('{cyc + 1, 32'(a)});
        q_rgb.push_back('{cyc + 3, (b && m_synced) ? 32'(pal_rgb(rom_f(a))) : 32'd0});
        @(negedge vga_clk);
    endtask

    task automatic tail(input int y);
        for (int x = SCREEN_W; x < SCREEN_W + 3; x++) drive(x, y, 1'b0);
    endtask

    task automatic frame_rest(input int y0);
        for (int y = y0; y < SCREEN_H; y++) begin
            drive(0, y, 1'b1);
            drive(SCREEN_W, y, 1'b0);
        end
        drive(0, SCREEN_H, 1'b0);
        drive(0, SCREEN_H + 1, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        q_addr.delete();
        q_rgb.delete();
        m_synced = 1'b0;
        m_off    = 0;
        m_addr   = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge vga_clk);
        n_checks++;
        if (rom_address !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_addr got=%0d exp=0", rom_address);
        end
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_rgb got=%h exp=000", {red, green, blue});
        end
        rst_n = 1'b1;
        // Mid-frame after reset: must stay black with blank active.
        for (int x = 0; x < 20; x++) begin
            drive(x, 50, 1'b1);
            n_checks++;
            if ({red, green, blue} !== 12'h000) begin
                n_fail++;
                $display("FAIL unsynced_rgb x=%0d got=%h exp=000", x, {red, green, blue});
            end
        end
        tail(50);
    endtask

    task automatic test_line0();
        for (int x = 0; x < SCREEN_W; x++) begin
            drive(x, 0, 1'b1);
            if (x == 0 || x == 4 || x == 639) begin
                n_checks++;
                if (rom_address !== ((x == 0) ? 17'd0 : (x == 4) ? 17'd1 : 17'd174)) begin
                    n_fail++;
                    $display("FAIL line0_addr x=%0d got=%0d", x, rom_address);
                end
            end
        end
        tail(0);
        drive(SCREEN_W + 3, 0, 1'b0);
        n_checks++;
        if (rom_address !== 17'd174) begin
            n_fail++;
            $display("FAIL hold_addr got=%0d exp=174", rom_address);
        end
    endtask

    task automatic test_rows();
        for (int y = 1; y < SCREEN_H; y++) begin
            drive(0, y, 1'b1);
            if (y == 1) begin
                n_checks++;
                if (rom_address !== 17'd175) begin
                    n_fail++;
                    $display("FAIL row1_addr got=%0d exp=175", rom_address);
                end
            end
            if (y == 479) begin
                n_checks++;
                if (rom_address !== 17'd83825) begin
                    n_fail++;
                    $display("FAIL row479_addr got=%0d exp=83825", rom_address);
                end
            end
            drive(SCREEN_W, y, 1'b0);
        end
        drive(0, SCREEN_H, 1'b0);
        drive(0, SCREEN_H + 1, 1'b0);
    endtask

    task automatic test_blank();
        for (int x = 0; x < SCREEN_W; x++) begin
            drive(x, 0, x < 100);
            // Output now shows pixel x-2: x=99 (texel 27 -> bd4), x=100 blanked.
            if (x == 101) begin
                n_checks++;
                if ({red, green, blue} !== 12'hbd4) begin
                    n_fail++;
                    $display("FAIL blank_on got=%h exp=bd4", {red, green, blue});
                end
            end
            if (x == 102) begin
                n_checks++;
                if ({red, green, blue} !== 12'h000) begin
                    n_fail++;
                    $display("FAIL blank_off got=%h exp=000", {red, green, blue});
                end
            end
        end
        tail(0);
        frame_rest(1);
    endtask

    task automatic test_scroll();
        logic [16:0] exp0;
        logic [16:0] exp639;
        scroll_x = 10'd0;
        drive(0, 0, 1'b1);
        tail(0);
        for (int y = 1; y <= 5; y++) begin
            if (y == 3) scroll_x = 10'd10;
            drive(0, y, 1'b1);
            drive(SCREEN_W, y, 1'b0);
        end
        n_checks++;
        if (rom_address !== 17'd875) begin
            n_fail++;
            $display("FAIL scroll_midframe got=%0d exp=875", rom_address);
        end
        frame_rest(6);
        exp0   = SCROLL_EN ? 17'd10 : 17'd0;
        exp639 = SCROLL_EN ? 17'd9  : 17'd174;
        for (int x = 0; x < SCREEN_W; x++) begin
            drive(x, 0, 1'b1);
            if (x == 0) begin
                n_checks++;
                if (rom_address !== exp0) begin
                    n_fail++;
                    $display("FAIL scroll_x0 got=%0d exp=%0d", rom_address, exp0);
                end
            end
            if (x == 639) begin
                n_checks++;
                if (rom_address !== exp639) begin
                    n_fail++;
                    $display("FAIL scroll_x639 got=%0d exp=%0d", rom_address, exp639);
                end
            end
        end
        tail(0);
        frame_rest(1);
        scroll_x = 10'd200;
        drive(0, 0, 1'b1);
        n_checks++;
        if (rom_address !== exp0) begin
            n_fail++;
            $display("FAIL scroll_range got=%0d exp=%0d", rom_address, exp0);
        end
        tail(0);
        frame_rest(1);
        scroll_x = 10'd0;
    endtask

    task automatic test_reset_midframe();
        drive(0, 0, 1'b1);
        tail(0);
        for (int y = 1; y < 200; y++) begin
            drive(0, y, 1'b1);
            drive(SCREEN_W, y, 1'b0);
        end
        for (int x = 0; x < 50; x++) drive(x, 200, 1'b1);
        apply_reset();
        #1;
        n_checks++;
        if (rom_address !== 17'd0) begin
            n_fail++;
            $display("FAIL async_reset_addr got=%0d exp=0", rom_address);
        end
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset_rgb got=%h exp=000", {red, green, blue});
        end
        @(negedge vga_clk);
        @(negedge vga_clk);
        rst_n = 1'b1;
        for (int x = 50; x < SCREEN_W; x++) begin
            drive(x, 200, 1'b1);
            n_checks++;
            if ({red, green, blue} !== 12'h000) begin
                n_fail++;
                $display("FAIL post_reset_black x=%0d got=%h", x, {red, green, blue});
            end
        end
        tail(200);
        frame_rest(201);
        for (int x = 0; x < SCREEN_W; x++) begin
            drive(x, 0, 1'b1);
            if (x == 4 || x == 639) begin
                n_checks++;
                if (rom_address !== ((x == 4) ? 17'd1 : 17'd174)) begin
                    n_fail++;
                    $display("FAIL resync_addr x=%0d got=%0d", x, rom_address);
                end
            end
            if (x == 101) begin
                n_checks++;
                if ({red, green, blue} !== 12'hbd4) begin
                    n_fail++;
                    $display("FAIL resync_rgb got=%h exp=bd4", {red, green, blue});
                end
            end
        end
        tail(0);
    endtask

    initial begin
        @(negedge vga_clk);
        test_reset();
        test_line0();
        test_rows();
        test_blank();
        test_scroll();
        test_reset_midframe();
        repeat (4) @(negedge vga_clk);
        n_checks++;
        if (q_addr.size() + q_rgb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d pending exp=0", q_addr.size() + q_rgb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
